// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - HD44780 8-bit write engine: power-up init, then line-1 refresh of eight ASCII digits
module lcd_char_writer #(
    parameter int POWERUP_CYCLES = 20000,
    parameter int STEP_CYCLES    = 50,
    parameter int E_HIGH         = 20,
    parameter int CLEAR_CYCLES   = 2000
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        en,
    input  logic [63:0] digits,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data,
    output logic        init_done,
    output logic        frame_done
);

    localparam int MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC = (MAX_A > STEP_CYCLES) ? MAX_A : STEP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(E_HIGH);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FSET,
        S_DISP,
        S_ENTRY,
        S_CLEAR,
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       char_q, char_d;
    logic [63:0]      snap_q, snap_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             lcd_e_q, lcd_e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic [CNT_W-1:0] last_tick;
    logic [7:0]       snap_byte;
    logic             bus_step;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_PWRUP;
            tick_q       <= '0;
            char_q       <= '0;
            snap_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            char_q       <= char_d;
            snap_q       <= snap_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        char_d      = char_q;
        snap_d      = snap_q;
        init_done_d = init_done_q;

        case (state_q)
            S_PWRUP: last_tick = P_LAST;
            S_CLEAR: last_tick = C_LAST;
            default: last_tick = S_LAST;
        endcase

        if (state_q == S_IDLE) begin
            if (en) begin
                state_d = S_ADDR;
                tick_d  = '0;
            end
        end else if (tick_q == last_tick) begin
            tick_d = '0;
            case (state_q)
                S_PWRUP: state_d = S_FSET;
                S_FSET:  state_d = S_DISP;
                S_DISP:  state_d = S_ENTRY;
                S_ENTRY: state_d = S_CLEAR;
                S_CLEAR: begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
                S_ADDR: begin
                    state_d = S_DATA;
                    char_d  = 3'd0;
                end
                S_DATA: begin
                    // en is only looked at on frame boundaries, so frames are never cut short
                    if (char_q == 3'd7) begin
                        state_d = en ? S_ADDR : S_IDLE;
                    end else begin
                        char_d = char_q + 3'd1;
                    end
                end
                default: state_d = S_PWRUP;
            endcase
        end else begin
            tick_d = tick_q + 1'b1;
        end

        if (state_q == S_ADDR && tick_q == '0) begin
            snap_d = digits;
        end
    end

    // Bus outputs are decoded from the next state/tick so the registered pins line up with tick 0
    always_comb begin
        case (char_d)
            3'd0:    snap_byte = snap_q[63:56];
            3'd1:    snap_byte = snap_q[55:48];
            3'd2:    snap_byte = snap_q[47:40];
            3'd3:    snap_byte = snap_q[39:32];
            3'd4:    snap_byte = snap_q[31:24];
            3'd5:    snap_byte = snap_q[23:16];
            3'd6:    snap_byte = snap_q[15:8];
            default: snap_byte = snap_q[7:0];
        endcase

        lcd_rs_d   = 1'b0;
        lcd_data_d = 8'h00;
        bus_step   = 1'b1;
        case (state_d)
            S_FSET:  lcd_data_d = 8'h38;
            S_DISP:  lcd_data_d = 8'h0C;
            S_ENTRY: lcd_data_d = 8'h06;
            S_CLEAR: lcd_data_d = 8'h01;
            S_ADDR:  lcd_data_d = 8'h80;
            S_DATA: begin
                lcd_rs_d   = 1'b1;
                lcd_data_d = snap_byte;
            end
            default: bus_step = 1'b0;
        endcase

        lcd_e_d      = bus_step && (tick_d != '0) && (tick_d <= E_LAST);
        frame_done_d = (state_d == S_DATA) && (char_d == 3'd7) && (tick_d == S_LAST);
    end

    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule
